// File: rtl/conv_job_sched_if.sv
// Job issue / result return channel between the scheduler and the convolution datapath.
// No latency of its own; pure signal bundle.
// Backpressure: job_ready stalls the scheduler; res_valid returns one credit per pulse.
interface conv_job_sched_if #(
    parameter int OCH_W = 2,
    parameter int CW    = 6
);
    logic                  job_valid;
    logic                  job_ready;
    logic [OCH_W-1:0]      job_och;
    logic [CW-1:0]         job_orow;
    logic [CW-1:0]         job_ocol;
    logic signed [CW+1:0]  job_irow;
    logic signed [CW+1:0]  job_icol;
    logic                  res_valid;

    modport master (
        output job_valid, job_och, job_orow, job_ocol, job_irow, job_icol,
        input  job_ready, res_valid
    );

    modport slave (
        input  job_valid, job_och, job_orow, job_ocol, job_irow, job_icol,
        output job_ready, res_valid
    );
endinterface

// File: rtl/conv_job_sched.sv
// Walks every (och, orow, ocol) of a conv layer and issues one window job per output pixel.
// Latency: go -> first job_valid 1 cycle; one job per cycle while credits and job_ready allow.
// Backpressure: job fields held while job_ready is low; issue pauses at MAX_OUT jobs in flight.
module conv_job_sched #(
    parameter int IN_DIM  = 128,
    parameter int K       = 5,
    parameter int PAD     = 2,
    parameter int STRIDE  = 2,
    parameter int OUT_CH  = 4,
    parameter int MAX_OUT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    conv_job_sched_if.master job_if,
    output logic             busy,
    output logic             flag,
    output logic             err
);
    localparam int OUT_DIM = (IN_DIM + 2*PAD - K) / STRIDE + 1;
    localparam int CW      = $clog2(OUT_DIM);
    localparam int OCH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int TOTAL   = OUT_CH * OUT_DIM * OUT_DIM;
    localparam int OW      = $clog2(MAX_OUT + 1);
    localparam int CPW     = $clog2(TOTAL + 1);

    localparam logic [CW-1:0]        LAST_POS = CW'(OUT_DIM - 1);
    localparam logic [OCH_W-1:0]     LAST_CH  = OCH_W'(OUT_CH - 1);
    localparam logic signed [CW+1:0] STRIDE_S = (CW+2)'(STRIDE);
    localparam logic signed [CW+1:0] PAD_S    = (CW+2)'(PAD);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [OCH_W-1:0] och;
    logic [CW-1:0]    orow;
    logic [CW-1:0]    ocol;
    logic [OW-1:0]    outstanding;
    logic [CPW-1:0]   completed;
    logic             valid_r;

    logic             xfer;
    logic             res_ok;
    logic             last_job;
    logic [OW-1:0]    out_nxt;

    // The job descriptor is the walk counters themselves, so it is stable by construction.
    assign job_if.job_valid = valid_r;
    assign job_if.job_och   = och;
    assign job_if.job_orow  = orow;
    assign job_if.job_ocol  = ocol;
    assign job_if.job_irow  = $signed({2'b00, orow}) * STRIDE_S - PAD_S;
    assign job_if.job_icol  = $signed({2'b00, ocol}) * STRIDE_S - PAD_S;

    // Handshake decode and next in-flight count; a result with nothing in flight is ignored.
    always_comb begin
        xfer     = valid_r && job_if.job_ready;
        res_ok   = job_if.res_valid && (outstanding != '0);
        last_job = (och == LAST_CH) && (orow == LAST_POS) && (ocol == LAST_POS);
        out_nxt  = outstanding;
        if (xfer && !res_ok) begin
            out_nxt = outstanding + OW'(1);
        end else if (!xfer && res_ok) begin
            out_nxt = outstanding - OW'(1);
        end
    end

    // Layer sequencer: raster walk with och outermost, credit-gated issue, drain, done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            och         <= '0;
            orow        <= '0;
            ocol        <= '0;
            outstanding <= '0;
            completed   <= '0;
            valid_r     <= 1'b0;
            busy        <= 1'b0;
            flag        <= 1'b0;
            err         <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            completed   <= completed + CPW'(res_ok);
            if (job_if.res_valid && (outstanding == '0)) begin
                err <= 1'b1;
            end
            flag <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (go) begin
                        state       <= ISSUE;
                        och         <= '0;
                        orow        <= '0;
                        ocol        <= '0;
                        outstanding <= '0;
                        completed   <= '0;
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        valid_r     <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (ocol == LAST_POS) begin
                            ocol <= '0;
                            if (orow == LAST_POS) begin
                                orow <= '0;
                                och  <= och + OCH_W'(1);
                            end else begin
                                orow <= orow + CW'(1);
                            end
                        end else begin
                            ocol <= ocol + CW'(1);
                        end
                    end
                    // Credits only shrink through a transfer, so an offered job is never withdrawn.
                    if (xfer && last_job) begin
                        state   <= DRAIN;
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= (out_nxt < OW'(MAX_OUT));
                    end
                end
                DRAIN: begin
                    if ((completed == CPW'(TOTAL)) && (outstanding == '0)) begin
                        state <= DONE;
                        flag  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_job_sched.sv
module tb_conv_job_sched;
    localparam int IN_DIM  = 8;
    localparam int K       = 5;
    localparam int PAD     = 2;
    localparam int STRIDE  = 2;
    localparam int OUT_CH  = 2;
    localparam int MAX_OUT = 4;
    localparam int OUT_DIM = (IN_DIM + 2*PAD - K) / STRIDE + 1;
    localparam int CW      = $clog2(OUT_DIM);
    localparam int OCH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
    localparam int NJOBS   = OUT_CH * OUT_DIM * OUT_DIM;
    localparam int FW      = OCH_W + 2*CW + 2*(CW+2);

    logic clock = 1'b0;
    logic reset;
    logic go;
    logic busy, flag, err;

    conv_job_sched_if #(.OCH_W(OCH_W), .CW(CW)) jif ();

    conv_job_sched #(
        .IN_DIM(IN_DIM), .K(K), .PAD(PAD), .STRIDE(STRIDE),
        .OUT_CH(OUT_CH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .go    (go),
        .job_if(jif),
        .busy  (busy),
        .flag  (flag),
        .err   (err)
    );

    always #5 clock = ~clock;

    logic [FW-1:0] fields;
    assign fields = {jif.job_och, jif.job_orow, jif.job_ocol, jif.job_irow, jif.job_icol};

    // Reference model state
    logic [FW-1:0] exp_job [NJOBS];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_idx, inflight, xfers, flags, first_x, last_x;
    int ret_q[$];
    int ret_dmin = 2, ret_dmax = 2;
    bit hold_pending, go_on_flag;
    logic [FW-1:0] held;

    // Expected job list from the layer definition: och outermost, then row, then col.
    task automatic build_expected();
        int i = 0;
        for (int c = 0; c < OUT_CH; c++)
            for (int r = 0; r < OUT_DIM; r++)
                for (int q = 0; q < OUT_DIM; q++) begin
                    exp_job[i] = {OCH_W'(c), CW'(r), CW'(q),
                                  (CW+2)'(r*STRIDE - PAD), (CW+2)'(q*STRIDE - PAD)};
                    i++;
                end
    endtask

    // One clock: observe at negedge, drive inputs, account for the transfer/result at next posedge.
    // rmode: 0 no results, 1 results when due, 2 force one pending result, 3 spurious result.
    task automatic cycle(input bit rdy, input bit go_i, input int rmode);
        bit x, found, legit;
        @(negedge clock);
        if (hold_pending) begin
            total++;
            if (jif.job_valid !== 1'b1 || fields !== held) begin
                bad++;
                $display("FAIL hold: valid=%b fields=%h required valid=1 fields=%h", jif.job_valid, fields, held);
            end
        end
        if (flag === 1'b1) begin
            flags++;
            total++;
            if (busy !== 1'b0 || exp_idx != NJOBS || ret_q.size() != 0) begin
                bad++;
                $display("FAIL flag_ctx: busy=%b jobs=%0d pending=%0d required busy=0 jobs=%0d pending=0",
                         busy, exp_idx, ret_q.size(), NJOBS);
            end
        end
        jif.job_ready = rdy;
        go = go_i || (go_on_flag && flag === 1'b1);
        jif.res_valid = 1'b0;
        if (rmode == 3) begin
            jif.res_valid = 1'b1;
        end else if (rmode != 0) begin
            found = 1'b0;
            for (int k = 0; k < ret_q.size(); k++) begin
                if (!found && (rmode == 2 || ret_q[k] <= cyc)) begin
                    found = 1'b1;
                    ret_q.delete(k);
                end
            end
            jif.res_valid = found;
        end
        legit = jif.res_valid && inflight > 0;
        x = (jif.job_valid === 1'b1) && rdy;
        if (x) begin
            total++;
            if (exp_idx >= NJOBS) begin
                bad++;
                $display("FAIL extra_job: got %h after %0d jobs", fields, NJOBS);
            end else if (fields !== exp_job[exp_idx]) begin
                bad++;
                $display("FAIL job_%0d: got %h required %h", exp_idx, fields, exp_job[exp_idx]);
            end
            exp_idx++;
            xfers++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            ret_q.push_back(cyc + $urandom_range(ret_dmin, ret_dmax));
            inflight++;
        end
        if (legit) inflight--;
        total++;
        if (inflight > MAX_OUT) begin
            bad++;
            $display("FAIL credit: in flight %0d required <= %0d", inflight, MAX_OUT);
        end
        hold_pending = (jif.job_valid === 1'b1) && !rdy;
        held = fields;
        cyc++;
    endtask

    task automatic start_layer();
        exp_idx = 0; inflight = 0; first_x = -1; last_x = -1;
        ret_q.delete();
        hold_pending = 1'b0;
        cycle(1'b0, 1'b1, 0);
    endtask

    task automatic run_layer(input string nm, input bit rnd, input int budget);
        int n = 0;
        int f0 = flags;
        while (flags == f0 && n < budget) begin
            cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1);
            n++;
        end
        total++;
        if (flags == f0) begin
            bad++;
            $display("FAIL %s_timeout: no flag after %0d cycles", nm, budget);
        end
        repeat (3) cycle(1'b1, 1'b0, 1);
        total++;
        if (exp_idx != NJOBS) begin
            bad++;
            $display("FAIL %s_count: jobs=%0d required %0d", nm, exp_idx, NJOBS);
        end
        total++;
        if (flags != f0 + 1) begin
            bad++;
            $display("FAIL %s_flags: flags=%0d required 1", nm, flags - f0);
        end
        total++;
        if (busy !== 1'b0 || jif.job_valid !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b valid=%b err=%b required 0 0 0", nm, busy, jif.job_valid, err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if (jif.job_valid !== 1'b0 || busy !== 1'b0 || flag !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: valid=%b busy=%b flag=%b err=%b required 0", jif.job_valid, busy, flag, err);
        end
        total++;
        if (fields !== {OCH_W'(0), CW'(0), CW'(0), (CW+2)'(-PAD), (CW+2)'(-PAD)}) begin
            bad++;
            $display("FAIL reset_fields: got %h", fields);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_layer();
        ret_dmin = 2; ret_dmax = 2;
        start_layer();
        @(posedge clock); #1;
        total++;
        if (jif.job_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL go_latency: valid=%b busy=%b required 1 1", jif.job_valid, busy);
        end
        run_layer("full", 1'b0, 400);
        total++;
        if (last_x - first_x != NJOBS - 1) begin
            bad++;
            $display("FAIL throughput: %0d cycles for %0d jobs required %0d", last_x - first_x + 1, NJOBS, NJOBS);
        end
    endtask

    task automatic test_credit();
        int x0;
        ret_dmin = 1; ret_dmax = 6;
        start_layer();
        x0 = xfers;
        repeat (8) cycle(1'b1, 1'b0, 0);
        total++;
        if (xfers - x0 != MAX_OUT || jif.job_valid !== 1'b0) begin
            bad++;
            $display("FAIL credit_stop: xfers=%0d valid=%b required %0d 0", xfers - x0, jif.job_valid, MAX_OUT);
        end
        cycle(1'b1, 1'b0, 2);
        repeat (6) cycle(1'b1, 1'b0, 0);
        total++;
        if (xfers - x0 != MAX_OUT + 1) begin
            bad++;
            $display("FAIL credit_one: xfers=%0d required %0d", xfers - x0, MAX_OUT + 1);
        end
        run_layer("credit", 1'b1, 2000);
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [FW-1:0] snap;
        ret_dmin = 1; ret_dmax = 5;
        start_layer();
        repeat (5) cycle(1'($urandom_range(0, 1)), 1'b0, 1);
        while (jif.job_valid !== 1'b1 && n < 20) begin
            cycle(1'b0, 1'b0, 1);
            n++;
        end
        snap = fields;
        repeat (5) cycle(1'b0, 1'b0, 1);
        total++;
        if (jif.job_valid !== 1'b1 || fields !== snap) begin
            bad++;
            $display("FAIL bp_stall: valid=%b fields=%h required 1 %h", jif.job_valid, fields, snap);
        end
        run_layer("bp", 1'b1, 2000);
    endtask

    task automatic test_simul_and_err();
        int x0;
        ret_dmin = 1; ret_dmax = 4;
        start_layer();
        x0 = xfers;
        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 2);
        repeat (4) cycle(1'b1, 1'b0, 0);
        total++;
        if (xfers - x0 != 5 || jif.job_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul: xfers=%0d valid=%b required 5 0", xfers - x0, jif.job_valid);
        end
        run_layer("simul", 1'b1, 2000);
        cycle(1'b0, 1'b0, 3);
        @(posedge clock); #1;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set: err=%b required 1", err);
        end
        start_layer();
        @(posedge clock); #1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
        run_layer("after_err", 1'b1, 2000);
    endtask

    task automatic test_reset_mid();
        int x0, n = 0;
        ret_dmin = 1; ret_dmax = 3;
        start_layer();
        x0 = xfers;
        while (xfers - x0 < 10 && n < 200) begin
            cycle(1'b1, 1'b0, 1);
            n++;
        end
        @(negedge clock);
        reset = 1'b1; go = 1'b0; jif.job_ready = 1'b0; jif.res_valid = 1'b0;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || jif.job_valid !== 1'b0 || flag !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: busy=%b valid=%b flag=%b required 0 0 0", busy, jif.job_valid, flag);
        end
        reset = 1'b0;
        start_layer();
        run_layer("restart", 1'b1, 2000);
    endtask

    task automatic test_go_ignored();
        ret_dmin = 1; ret_dmax = 4;
        start_layer();
        repeat (5) cycle(1'b1, 1'b0, 1);
        cycle(1'b1, 1'b1, 1);
        cycle(1'b0, 1'b1, 1);
        go_on_flag = 1'b1;
        run_layer("go_ign", 1'b1, 2000);
        go_on_flag = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; go = 1'b0;
        jif.job_ready = 1'b0; jif.res_valid = 1'b0;
        xfers = 0; flags = 0; go_on_flag = 1'b0; hold_pending = 1'b0;
        build_expected();
        test_reset();
        test_full_layer();
        test_credit();
        test_backpressure();
        test_simul_and_err();
        test_reset_mid();
        test_go_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
